// File: rtl/npu_out_deskew_if.sv
// Row-in / row-out bundle for the PE array output realignment stage.
// No logic of its own; carries combinational wires only.
// Backpressure: out_ready from the consumer, qualified by out_valid.
interface npu_out_deskew_if #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
);
  logic                      in_valid;
  logic [DWIDTH-1:0]         col0;
  logic [DWIDTH-1:0]         col1;
  logic [DWIDTH-1:0]         col2;
  logic                      out_valid;
  logic                      out_ready;
  logic [3*DWIDTH-1:0]       out_data;
  logic [$clog2(DEPTH):0]    out_count;
  logic                      frame_done;
  logic                      overflow;

  // Array/consumer side: drives the strobe, columns and ready.
  modport master (
    output in_valid, col0, col1, col2, out_ready,
    input  out_valid, out_data, out_count, frame_done, overflow
  );

  // Deskew block side.
  modport slave (
    input  in_valid, col0, col1, col2, out_ready,
    output out_valid, out_data, out_count, frame_done, overflow
  );
endinterface

// File: rtl/npu_out_deskew.sv
// Removes the one-cycle-per-column skew of the PE array and buffers whole rows in a FIFO.
// Latency: in_valid at t -> pushed on edge ending t+LAT+2, out_valid/out_data from t+LAT+3.
// Backpressure: out_ready holds the registered head; rows arriving to a full, non-popping FIFO are dropped and overflow sticks.
module npu_out_deskew #(
  parameter int DWIDTH = 16,
  parameter int LAT    = 2,
  parameter int DEPTH  = 8,
  parameter int ROWS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  npu_out_deskew_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 3 * DWIDTH;

  // vld_sr[k-1] is high k cycles after in_valid, so tap k of the valid pipe is vld_sr[k-1].
  logic [LAT+1:0]    vld_sr;
  logic              tap_c0;
  logic              tap_c1;
  logic              tap_push;

  logic [DWIDTH-1:0] c0_d1;
  logic [DWIDTH-1:0] c0_d2;
  logic [DWIDTH-1:0] c1_d1;
  logic [RW-1:0]     row;

  logic [RW-1:0]     mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_nxt;
  logic [CW-1:0]     count;
  logic [RW-1:0]     head;
  logic              full;
  logic              pop;
  logic              push_acc;

  logic [7:0]        row_cnt;
  logic              frame_pulse;
  logic              ovf;

  assign tap_c0   = vld_sr[LAT-1];
  assign tap_c1   = vld_sr[LAT];
  assign tap_push = vld_sr[LAT+1];

  // col2 arrives last and is used live; the other two are held back to line up with it.
  assign row      = {bus.col2, c1_d1, c0_d2};

  assign full     = (count == CW'(DEPTH));
  assign pop      = (count != '0) && bus.out_ready;
  // A full FIFO can still take a row when the head leaves on the same edge.
  assign push_acc = tap_push && (!full || pop);
  assign rd_nxt   = rd_ptr + AW'(1);

  // Valid pipe; a strobe coincident with clear is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT:0], bus.in_valid};
    end
  end

  // Deskew stages: each loads only when its own tap is valid, so back-to-back rows do not collide.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      c0_d1 <= '0;
      c0_d2 <= '0;
      c1_d1 <= '0;
    end else begin
      if (tap_c0) c0_d1 <= bus.col0;
      if (tap_c1) begin
        c0_d2 <= c0_d1;
        c1_d1 <= bus.col1;
      end
    end
  end

  // Row storage; contents need no reset because only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= row;
  end

  // Pointers and exact occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_nxt;
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered head: refilled from the incoming row when the FIFO is (or becomes) empty, else from the next slot.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head <= '0;
    end else if (push_acc && ((count == '0) || (pop && (count == CW'(1))))) begin
      head <= row;
    end else if (pop && (count > CW'(1))) begin
      head <= mem[rd_nxt];
    end
  end

  // Frame row counter counts every push attempt, dropped or not, and pulses on the last row.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row_cnt     <= '0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      if (tap_push) begin
        if (row_cnt == 8'(ROWS - 1)) begin
          row_cnt     <= '0;
          frame_pulse <= 1'b1;
        end else begin
          row_cnt <= row_cnt + 8'd1;
        end
      end
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ovf <= 1'b0;
    end else if (tap_push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = head;
  assign bus.out_count  = count;
  assign bus.frame_done = frame_pulse;
  assign bus.overflow   = ovf;

endmodule

// File: tb/tb_npu_out_deskew.sv
// Directed bench for npu_out_deskew: single row, back-to-back rows, overflow, full push+pop, flush, random ready.
// Latency: expects in_valid at t -> out_valid at t+5 with LAT=2.
// Backpressure: out_ready driven per cycle by the stimulus; pops captured by a negedge monitor.
module tb_npu_out_deskew;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int ROWS  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  npu_out_deskew_if #(.DWIDTH(DW), .DEPTH(DEPTH)) bus ();

  npu_out_deskew #(.DWIDTH(DW), .LAT(LAT), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit [15:0] s0 [0:8191];
  bit [15:0] s1 [0:8191];
  bit [15:0] s2 [0:8191];
  bit        lv [0:8191];
  bit [47:0] lw [0:8191];

  logic [47:0] got_q [$];
  logic [47:0] exp_q [$];
  int fd_n    = 0;
  int m_occ   = 0;
  int drops   = 0;
  int cnt_bad = 0;
  bit mdl_on  = 0;
  bit m_pop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rw(input int r);
    logic [11:0] id;
    id = r[11:0];
    return {4'hC, id, 4'hB, id, 4'hA, id};
  endfunction

  // Column driver emulating the skewed array: values scheduled by launch appear LAT, LAT+1, LAT+2 cycles later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    bus.col0 = s0[cyc];
    bus.col1 = s1[cyc];
    bus.col2 = s2[cyc];
  end

  // Monitor: captures pops and frame pulses; during the random phase also runs an occupancy model.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (bus.frame_done) fd_n++;
    if (mdl_on) begin
      m_pop = (m_occ > 0) && bus.out_ready;
      if (int'(bus.out_count) != m_occ) cnt_bad++;
      if (lv[cyc-LAT-2]) begin
        if (m_occ < DEPTH || m_pop) begin
          exp_q.push_back(lw[cyc-LAT-2]);
          if (!m_pop) m_occ++;
        end else begin
          drops++;
        end
      end else if (m_pop) begin
        m_occ--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch_vals(input bit [15:0] a, input bit [15:0] b, input bit [15:0] c);
    bus.in_valid = 1'b1;
    s0[cyc+LAT]   = a;
    s1[cyc+LAT+1] = b;
    s2[cyc+LAT+2] = c;
    lv[cyc] = 1'b1;
    lw[cyc] = {c, b, a};
  endtask

  task automatic launch(input int r);
    logic [47:0] w;
    w = rw(r);
    launch_vals(w[15:0], w[31:16], w[47:32]);
  endtask

  task automatic do_clear();
    tick();
    bus.in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Flush mid-stream with four rows queued and two more in the deskew stages.
  task automatic flush_test(input bit use_rst, input int base);
    bit stale;
    int fd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rst_n = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      if (i <= 3 || i == 6) launch(base + i);
      else if (i == 8) begin
        launch(base + 99);
        if (use_rst) rst_n = 1'b0;
        else clear = 1'b1;
      end
      @(negedge clk);
      if (i == 8) begin
        check("fl_pre_cnt", bus.out_count, 4);
        check("fl_pre_head", bus.out_data, rw(base));
      end
      if (i == 9) begin
        check("fl_vld", bus.out_valid, 0);
        check("fl_dat", bus.out_data, 0);
        check("fl_cnt", bus.out_count, 0);
        check("fl_fd", bus.frame_done, 0);
        check("fl_ovf", bus.overflow, 0);
      end
    end
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      stale |= bus.out_valid;
    end
    check("fl_no_stale", stale, 0);
    got_q.delete();
    fd0 = fd_n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.in_valid = 1'b0;
      if (i < 3) launch(base + 10 + i);
      @(negedge clk);
      if (i == 7) check("fl_fd_align", bus.frame_done, 1);
    end
    check("fl_fd_cnt", fd_n - fd0, 1);
    check("fl_rows", got_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (got_q.size() > k) check("fl_row_dat", got_q[k], rw(base + 10 + k));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int fd0;
    int bad;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_vld", bus.out_valid, 0);
    check("rst_dat", bus.out_data, 0);
    check("rst_cnt", bus.out_count, 0);
    check("rst_fd", bus.frame_done, 0);
    check("rst_ovf", bus.overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single row: strobe at c, out_valid first at c+5
    tick();
    launch_vals(16'h0011, 16'h0022, 16'h0033);
    repeat (4) begin
      tick();
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("t1_vld_early", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("t1_vld", bus.out_valid, 1);
    check("t1_dat", bus.out_data, 48'h0033_0022_0011);
    check("t1_cnt", bus.out_count, 1);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t1_popped_vld", bus.out_valid, 0);
    check("t1_popped_cnt", bus.out_count, 0);

    // Three back-to-back rows, consumer always ready
    do_clear();
    bus.out_ready = 1'b1;
    fd0 = fd_n;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.in_valid = 1'b0;
      if (i < 3) launch(10 + i);
      @(negedge clk);
      check("t2_vld", bus.out_valid, (i >= 5 && i <= 7) ? 1 : 0);
      if (i >= 5 && i <= 7) check("t2_dat", bus.out_data, rw(10 + i - 5));
      check("t2_fd", bus.frame_done, (i == 7) ? 1 : 0);
      check("t2_cnt_le1", bus.out_count <= 1, 1);
    end
    check("t2_fd_cnt", fd_n - fd0, 1);

    // Ten rows into a stalled FIFO of eight
    do_clear();
    bus.out_ready = 1'b0;
    fd0 = fd_n;
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.in_valid = 1'b0;
      if (i < 10) launch(300 + i);
      @(negedge clk);
      if (i == 12) begin
        check("t3_cnt_full", bus.out_count, 8);
        check("t3_ovf_before", bus.overflow, 0);
      end
      if (i == 13) check("t3_ovf_rise", bus.overflow, 1);
    end
    check("t3_cnt_end", bus.out_count, 8);
    check("t3_fd_cnt", fd_n - fd0, 3);
    got_q.delete();
    tick();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t3_drained", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      if (got_q.size() > k) check("t3_order", got_q[k], rw(300 + k));
    check("t3_cnt_empty", bus.out_count, 0);
    check("t3_ovf_sticky", bus.overflow, 1);

    // Flush by clear, then by reset
    flush_test(1'b0, 500);
    flush_test(1'b1, 600);
    rst_n = 1'b1;

    // Full FIFO with push and pop on the same edge
    do_clear();
    got_q.delete();
    for (int i = 0; i < 19; i++) begin
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = (i == 17);
      if (i < 8) launch(40 + i);
      if (i == 13) launch(48);
      @(negedge clk);
      if (i == 12) check("t4_full", bus.out_count, 8);
      if (i == 17) check("t4_cnt_pre", bus.out_count, 8);
      if (i == 18) begin
        check("t4_cnt_same", bus.out_count, 8);
        check("t4_no_ovf", bus.overflow, 0);
        check("t4_head", bus.out_data, rw(41));
      end
    end
    tick();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t4_rows", got_q.size(), 9);
    for (int k = 0; k < 9; k++)
      if (got_q.size() > k) check("t4_order", got_q[k], rw(40 + k));

    // Continuous rows against a sparse random ready
    do_clear();
    got_q.delete();
    exp_q.delete();
    m_occ   = 0;
    drops   = 0;
    cnt_bad = 0;
    mdl_on  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      launch(1000 + i);
      bus.out_ready = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    mdl_on = 1'b0;
    check("t6_cnt_track", cnt_bad, 0);
    check("t6_delivered", got_q.size(), exp_q.size());
    check("t6_all_rows", got_q.size() + drops, 200);
    bad = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (got_q.size() <= k || got_q[k] !== exp_q[k]) bad++;
    check("t6_order", bad, 0);
    check("t6_ovf_vs_drops", bus.overflow, (drops != 0) ? 1 : 0);
    check("t6_empty", bus.out_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
